// File: rtl/nf_10g_rx_drop_fifo.sv
// rtl/nf_10g_rx_drop_fifo.sv - store-and-forward RX FIFO with whole-packet tail drop
// Packets are written speculatively and only become visible to the reader once tlast commits them.
module nf_10g_rx_drop_fifo #(
   parameter int C_DATA_WIDTH  = 256,
   parameter int C_TUSER_WIDTH = 128,
   parameter int C_DEPTH_LOG2  = 9
) (
   input  logic                        axis_aclk,
   input  logic                        axis_aresetn,
   input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [C_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                        s_axis_tlast,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [31:0]                 pkt_in_count,
   output logic [31:0]                 pkt_drop_count,
   output logic [C_DEPTH_LOG2:0]       fifo_used
);

   localparam int KW    = C_DATA_WIDTH / 8;
   localparam int MW    = C_DATA_WIDTH + KW + C_TUSER_WIDTH + 1;
   localparam int PW    = C_DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << C_DEPTH_LOG2;
   localparam logic [PW-1:0] FULL_LVL = {1'b1, {C_DEPTH_LOG2{1'b0}}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   logic [MW-1:0] mem [DEPTH];

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] wr_commit_q, wr_commit_d;
   logic [PW-1:0] rd_ptr_q;
   logic [31:0]   in_cnt_q, in_cnt_d;
   logic [31:0]   drop_cnt_q, drop_cnt_d;
   logic          tready_q;
   logic          out_valid_q;
   logic [MW-1:0] out_word_q;

   logic          beat, full, wr_en, load;
   logic [PW-1:0] used;

   assign beat = s_axis_tvalid && tready_q;
   assign full = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
   assign used = wr_commit_q - rd_ptr_q;
   assign load = (used != '0) && (!out_valid_q || m_axis_tready);

   // IDLE and WRITE share one path: in IDLE wr_ptr equals wr_commit, so the rollback is a no-op.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      in_cnt_d    = in_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      wr_en       = 1'b0;
      case (state_q)
         ST_IDLE, ST_WRITE: begin
            if (beat) begin
               if (!full) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (s_axis_tlast) begin
                     wr_commit_d = wr_ptr_q + 1'b1;
                     in_cnt_d    = in_cnt_q + 32'd1;
                     state_d     = ST_IDLE;
                  end else begin
                     state_d = ST_WRITE;
                  end
               end else begin
                  wr_ptr_d   = wr_commit_q;
                  drop_cnt_d = drop_cnt_q + 32'd1;
                  state_d    = s_axis_tlast ? ST_IDLE : ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (beat && s_axis_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (wr_en) mem[wr_ptr_q[C_DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         in_cnt_q    <= '0;
         drop_cnt_q  <= '0;
         tready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         in_cnt_q    <= in_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         tready_q    <= 1'b1;
      end
   end

   // Single output register gives first-word-fall-through; it holds while tvalid && !tready.
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
      end else if (load) begin
         rd_ptr_q    <= rd_ptr_q + 1'b1;
         out_valid_q <= 1'b1;
         out_word_q  <= mem[rd_ptr_q[C_DEPTH_LOG2-1:0]];
      end else if (m_axis_tready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign s_axis_tready  = tready_q;
   assign m_axis_tvalid  = out_valid_q;
   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_word_q;
   assign pkt_in_count   = in_cnt_q;
   assign pkt_drop_count = drop_cnt_q;
   assign fifo_used      = used;

endmodule

// File: tb/tb_nf_10g_rx_drop_fifo.sv
// tb/tb_nf_10g_rx_drop_fifo.sv - scoreboard bench for nf_10g_rx_drop_fifo at 16-beat depth
module tb_nf_10g_rx_drop_fifo;

   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int UW = 128;
   localparam int DL = 4;
   localparam int BW = DW + KW + UW + 1;

   logic          clk = 1'b0;
   logic          axis_aresetn;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic [31:0]   pkt_in_count, pkt_drop_count;
   logic [DL:0]   fifo_used;

   logic [BW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            beats_sent = 0;
   int            beats_rcvd = 0;
   bit            rand_ready = 1'b0;

   nf_10g_rx_drop_fifo #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .C_DEPTH_LOG2(DL)) dut (
      .axis_aclk(clk), .axis_aresetn(axis_aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .pkt_in_count(pkt_in_count), .pkt_drop_count(pkt_drop_count), .fifo_used(fifo_used)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
   end

   initial forever begin
      logic [BW-1:0] got, exp;
      @(negedge clk);
      if (axis_aresetn && m_axis_tvalid && m_axis_tready) begin
         got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
         n_checks++;
         beats_rcvd++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_beat_unexpected actual=%h required=<none>", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_fail++;
               $display("FAIL out_beat actual=%h required=%h", got, exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_pkt(input int n, input bit pass);
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      for (int i = 0; i < n; i++) begin
         for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
         k = $urandom;
         u = {$urandom, $urandom, $urandom, $urandom};
         s_axis_tdata  = d;
         s_axis_tkeep  = k;
         s_axis_tuser  = u;
         s_axis_tlast  = (i == n - 1);
         s_axis_tvalid = 1'b1;
         if (pass) begin
            exp_q.push_back({d, k, u, (i == n - 1)});
            beats_sent++;
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      check({name, "_used0"}, 64'(fifo_used), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      axis_aresetn  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tdata_lo", 64'(m_axis_tdata[63:0]), 64'd0);
      check("rst_in_count", 64'(pkt_in_count), 64'd0);
      check("rst_drop_count", 64'(pkt_drop_count), 64'd0);
      check("rst_used", 64'(fifo_used), 64'd0);
      axis_aresetn = 1'b1;
      @(posedge clk);
      #1;
      check("s_tready_after_rst", 64'(s_axis_tready), 64'd1);

      // 1: single packet, two-cycle commit-to-valid latency
      m_axis_tready = 1'b1;
      send_pkt(3, 1'b1);
      check("t1_tvalid_t1", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      check("t1_tvalid_t2", 64'(m_axis_tvalid), 64'd1);
      drain("t1");
      check("t1_in_count", 64'(pkt_in_count), 64'd1);

      // 2: 15 beats committed (one sits in the output register), 4-beat packet rolls back
      m_axis_tready = 1'b0;
      for (int p = 0; p < 5; p++) send_pkt(3, 1'b1);
      send_pkt(4, 1'b0);
      check("t2_in_count", 64'(pkt_in_count), 64'd6);
      check("t2_drop_count", 64'(pkt_drop_count), 64'd1);
      check("t2_used", 64'(fifo_used), 64'd14);
      check("t2_m_tvalid_held", 64'(m_axis_tvalid), 64'd1);
      m_axis_tready = 1'b1;
      drain("t2");

      // 3: FIFO full (16 stored + 1 in output register), single-beat packet dropped
      m_axis_tready = 1'b0;
      send_pkt(8, 1'b1);
      send_pkt(8, 1'b1);
      send_pkt(1, 1'b1);
      check("t3_used_full", 64'(fifo_used), 64'd16);
      check("t3_s_tready_a", 64'(s_axis_tready), 64'd1);
      send_pkt(1, 1'b0);
      check("t3_drop_count", 64'(pkt_drop_count), 64'd2);
      check("t3_in_count", 64'(pkt_in_count), 64'd9);
      check("t3_used_after", 64'(fifo_used), 64'd16);
      check("t3_s_tready_b", 64'(s_axis_tready), 64'd1);
      m_axis_tready = 1'b1;
      drain("t3");

      // 4: oversize packet dropped at beat 17, next packet intact
      send_pkt(20, 1'b0);
      check("t4_drop_count", 64'(pkt_drop_count), 64'd3);
      check("t4_used_empty", 64'(fifo_used), 64'd0);
      check("t4_no_output", 64'(m_axis_tvalid), 64'd0);
      send_pkt(2, 1'b1);
      check("t4_used_commit", 64'(fifo_used), 64'd2);
      check("t4_in_count", 64'(pkt_in_count), 64'd10);
      drain("t4");

      // 5: random tready, 100 packets paced so nothing can overflow
      beats_sent = 0;
      beats_rcvd = 0;
      rand_ready = 1'b1;
      for (int p = 0; p < 100; p++) begin
         int n;
         int t;
         n = $urandom_range(1, 8);
         t = 0;
         while (beats_sent - beats_rcvd + n > 16 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
         end
         send_pkt(n, 1'b1);
      end
      drain("t5");
      check("t5_in_count", 64'(pkt_in_count), 64'd110);
      check("t5_drop_count", 64'(pkt_drop_count), 64'd3);
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      m_axis_tready = 1'b0;
      @(posedge clk);
      #1;

      // 6: reset mid-packet with 2 packets stored
      send_pkt(2, 1'b0);
      send_pkt(2, 1'b0);
      s_axis_tdata  = '1;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      check("t6_used_pre", 64'(fifo_used), 64'd3);
      #2;
      axis_aresetn = 1'b0;
      #1;
      check("t6_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t6_m_tdata_lo", 64'(m_axis_tdata[63:0]), 64'd0);
      check("t6_in_count", 64'(pkt_in_count), 64'd0);
      check("t6_drop_count", 64'(pkt_drop_count), 64'd0);
      check("t6_used", 64'(fifo_used), 64'd0);
      check("t6_s_tready", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      axis_aresetn = 1'b1;
      @(posedge clk);
      #1;
      m_axis_tready = 1'b1;
      send_pkt(2, 1'b1);
      drain("t6");
      check("t6_in_after", 64'(pkt_in_count), 64'd1);
      check("t6_drop_after", 64'(pkt_drop_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
